// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
// Command/response sequencer for an external combinational ALU.
//
// A command is accepted in IDLE. For a legal opcode (0x0-0x9) the operands,
// flag input and opcode are registered onto the ALU drive ports. The FSM then
// spends exactly one EXEC cycle and captures the ALU result and flag. The
// response is held in RESP until it is consumed. An illegal opcode (0xA-0xF)
// skips EXEC and produces an error response straight away. The ALU drive
// ports are left untouched in that case.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (cmd_ready == state is IDLE)
//   cmd_op               : ALU opcode, 0x0-0x9 legal
//   cmd_a, cmd_b         : operands
//   cmd_flagin           : value for the ALU flag input
//   cmd_chain            : use the previous captured result as operand A
//   A, B, ALUFlagIN,
//   ALUControl           : registered drive to the ALU
//   ALUResult, ALUFlags  : combinational return from the ALU
//   rsp_valid/rsp_ready  : response handshake
//   rsp_result, rsp_flag,
//   rsp_err              : captured response
//   op_count             : completed responses, wraps at 256
// -----------------------------------------------------------------------------
module alu_ctrl #(
  parameter int ancho = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [ancho-1:0] cmd_a,
  input  logic [ancho-1:0] cmd_b,
  input  logic             cmd_flagin,
  input  logic             cmd_chain,
  output logic [ancho-1:0] A,
  output logic [ancho-1:0] B,
  output logic             ALUFlagIN,
  output logic [3:0]       ALUControl,
  input  logic [ancho-1:0] ALUResult,
  input  logic             ALUFlags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ancho-1:0] rsp_result,
  output logic             rsp_flag,
  output logic             rsp_err,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_cmd_ready;
  logic [ancho-1:0] r_a;
  logic [ancho-1:0] r_b;
  logic             r_flagin;
  logic [3:0]       r_ctrl;
  logic             r_rsp_valid;
  logic [ancho-1:0] r_rsp_result;
  logic             r_rsp_flag;
  logic             r_rsp_err;
  logic [7:0]       r_op_count;
  logic [ancho-1:0] r_last_result;

  // Opcodes 0x0-0x9 are implemented by the ALU.
  function automatic logic is_legal(input logic [3:0] op);
    return (op <= 4'h9);
  endfunction

  // Only these opcodes give a meaningful ALU flag. For the rest the flag is undefined.
  function automatic logic flag_defined(input logic [3:0] op);
    logic v;
    case (op)
      4'h2, 4'h6, 4'h8, 4'h9: v = 1'b1;
      default:                v = 1'b0;
    endcase
    return v;
  endfunction

  // Control FSM. Every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_a           <= {ancho{1'b0}};
      r_b           <= {ancho{1'b0}};
      r_flagin      <= 1'b0;
      r_ctrl        <= 4'h0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= {ancho{1'b0}};
      r_rsp_flag    <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_op_count    <= 8'd0;
      r_last_result <= {ancho{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_cmd_ready <= 1'b0;
            if (is_legal(cmd_op)) begin
              r_a      <= cmd_chain ? r_last_result : cmd_a;
              r_b      <= cmd_b;
              r_flagin <= cmd_flagin;
              r_ctrl   <= cmd_op;
              r_state  <= S_EXEC;
            end else begin
              // Error response goes out directly. The ALU drive and last_result are kept.
              r_rsp_result <= {ancho{1'b0}};
              r_rsp_flag   <= 1'b0;
              r_rsp_err    <= 1'b1;
              r_rsp_valid  <= 1'b1;
              r_state      <= S_RESP;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          // The operands have been stable on the ALU for one full cycle.
          r_rsp_result  <= ALUResult;
          r_last_result <= ALUResult;
          r_rsp_flag    <= flag_defined(r_ctrl) ? ALUFlags : 1'b0;
          r_rsp_err     <= 1'b0;
          r_rsp_valid   <= 1'b1;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_op_count  <= r_op_count + 8'd1;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign A          = r_a;
  assign B          = r_b;
  assign ALUFlagIN  = r_flagin;
  assign ALUControl = r_ctrl;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flag   = r_rsp_flag;
  assign rsp_err    = r_rsp_err;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed testbench for alu_ctrl with a behavioural 4-bit ALU attached.
// ALU opcodes: 0 AND, 1 OR, 2 ADD (carry), 3 XOR, 4 NOT A, 5 pass B,
// 6 SUB (borrow), 7 SHL, 8 ADD+cin (carry), 9 SUB-bin (borrow).
// The model drives flag=1 on ops without a defined flag, so masking is visible.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_flagin;
  logic       cmd_chain;
  logic [3:0] A;
  logic [3:0] B;
  logic       ALUFlagIN;
  logic [3:0] ALUControl;
  logic [3:0] ALUResult;
  logic       ALUFlags;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_flag;
  logic       rsp_err;
  logic [7:0] op_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_ctrl #(.ancho(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flagin(cmd_flagin), .cmd_chain(cmd_chain),
    .A(A), .B(B), .ALUFlagIN(ALUFlagIN), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .ALUFlags(ALUFlags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flag(rsp_flag), .rsp_err(rsp_err), .op_count(op_count)
  );

  // Behavioural combinational ALU
  always_comb begin
    logic [4:0] s;
    s         = 5'd0;
    ALUResult = 4'h0;
    ALUFlags  = 1'b1;
    case (ALUControl)
      4'h0: ALUResult = A & B;
      4'h1: ALUResult = A | B;
      4'h2: begin s = {1'b0, A} + {1'b0, B}; ALUResult = s[3:0]; ALUFlags = s[4]; end
      4'h3: ALUResult = A ^ B;
      4'h4: ALUResult = ~A;
      4'h5: ALUResult = B;
      4'h6: begin s = {1'b0, A} - {1'b0, B}; ALUResult = s[3:0]; ALUFlags = s[4]; end
      4'h7: ALUResult = {A[2:0], 1'b0};
      4'h8: begin s = {1'b0, A} + {1'b0, B} + {4'd0, ALUFlagIN}; ALUResult = s[3:0]; ALUFlags = s[4]; end
      4'h9: begin s = {1'b0, A} - {1'b0, B} - {4'd0, ALUFlagIN}; ALUResult = s[3:0]; ALUFlags = s[4]; end
      default: ALUResult = 4'h0;
    endcase
  end

  // Stimulus only: issue one command, measure its latency in cycles, return the response, consume it.
  task automatic run_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic fin, input logic chain,
                         output int lat, output logic [3:0] res, output logic flg, output logic err);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    cmd_flagin = fin; cmd_chain = chain; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = rsp_result; flg = rsp_flag; err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 4'h2; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({rsp_result, rsp_flag, rsp_err} !== 6'd0) begin errors++; $display("FAIL reset_rsp got=%h/%b/%b exp=0/0/0", rsp_result, rsp_flag, rsp_err); end
    checks++; if ({A, B, ALUFlagIN, ALUControl} !== 13'd0) begin errors++; $display("FAIL reset_alu_drive got=%h/%h/%b/%h exp=0", A, B, ALUFlagIN, ALUControl); end
    checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
  endtask

  task automatic test_add_carry();
    int lat; logic [3:0] r; logic f, e;
    run_cmd(4'h2, 4'hF, 4'h1, 1'b0, 1'b0, lat, r, f, e);
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got=%0d exp=2", lat); end
    checks++; if (r !== 4'h0) begin errors++; $display("FAIL add_result got=%h exp=0", r); end
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL add_flag got=%b exp=1", f); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL add_err got=%b exp=0", e); end
    checks++; if (op_count !== 8'd1) begin errors++; $display("FAIL add_op_count got=%0d exp=1", op_count); end
  endtask

  task automatic test_chain();
    int lat; logic [3:0] r; logic f, e;
    run_cmd(4'h0, 4'hC, 4'hA, 1'b0, 1'b0, lat, r, f, e);
    checks++; if (r !== 4'h8) begin errors++; $display("FAIL and_result got=%h exp=8", r); end
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL and_flag_masked got=%b exp=0", f); end
    run_cmd(4'h2, 4'h3, 4'h4, 1'b0, 1'b0, lat, r, f, e);
    checks++; if (r !== 4'h7 || f !== 1'b0) begin errors++; $display("FAIL add37 got=%h/%b exp=7/0", r, f); end
    run_cmd(4'h3, 4'h0, 4'hF, 1'b0, 1'b1, lat, r, f, e);
    checks++; if (r !== 4'h8) begin errors++; $display("FAIL chain_result got=%h exp=8", r); end
    checks++; if (A !== 4'h7) begin errors++; $display("FAIL chain_operand got=%h exp=7", A); end
  endtask

  task automatic test_illegal();
    int lat; logic [3:0] r; logic f, e; logic [7:0] c0;
    c0 = op_count;
    run_cmd(4'hA, 4'h5, 4'h6, 1'b1, 1'b0, lat, r, f, e);
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    checks++; if (e !== 1'b1 || r !== 4'h0 || f !== 1'b0) begin errors++; $display("FAIL illegal_rsp got=%h/%b/%b exp=0/0/1", r, f, e); end
    checks++; if (op_count !== c0 + 8'd1) begin errors++; $display("FAIL illegal_op_count got=%0d exp=%0d", op_count, c0 + 8'd1); end
    checks++; if ({A, B, ALUFlagIN, ALUControl} !== {4'h7, 4'hF, 1'b0, 4'h3}) begin errors++; $display("FAIL illegal_alu_drive got=%h/%h/%b/%h exp=7/f/0/3", A, B, ALUFlagIN, ALUControl); end
    run_cmd(4'hF, 4'h1, 4'h1, 1'b0, 1'b0, lat, r, f, e);
    checks++; if (e !== 1'b1 || lat !== 1) begin errors++; $display("FAIL illegal_f got err=%b lat=%0d exp=1/1", e, lat); end
    // last_result must still hold 8: 8 ^ 0 = 8
    run_cmd(4'h3, 4'h0, 4'h0, 1'b0, 1'b1, lat, r, f, e);
    checks++; if (r !== 4'h8 || e !== 1'b0) begin errors++; $display("FAIL illegal_last_result got=%h/%b exp=8/0", r, e); end
  endtask

  task automatic test_flag_ops();
    int lat; logic [3:0] r; logic f, e;
    run_cmd(4'h6, 4'h3, 4'h5, 1'b0, 1'b0, lat, r, f, e);
    checks++; if (r !== 4'hE || f !== 1'b1) begin errors++; $display("FAIL sub_borrow got=%h/%b exp=e/1", r, f); end
    run_cmd(4'h9, 4'h5, 4'h2, 1'b1, 1'b0, lat, r, f, e);
    checks++; if (r !== 4'h2 || f !== 1'b0) begin errors++; $display("FAIL sbb got=%h/%b exp=2/0", r, f); end
    run_cmd(4'h8, 4'h7, 4'h8, 1'b1, 1'b0, lat, r, f, e);
    checks++; if (r !== 4'h0 || f !== 1'b1) begin errors++; $display("FAIL adc got=%h/%b exp=0/1", r, f); end
    run_cmd(4'h7, 4'h9, 4'h0, 1'b0, 1'b0, lat, r, f, e);
    checks++; if (r !== 4'h2 || f !== 1'b0) begin errors++; $display("FAIL shl got=%h/%b exp=2/0", r, f); end
  endtask

  task automatic test_backpressure();
    int lat; logic [3:0] r; logic f, e; logic [7:0] c0; int n;
    c0 = op_count;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h1; cmd_a = 4'h5; cmd_b = 4'hA; cmd_chain = 1'b0; cmd_flagin = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout got=%b exp=1", rsp_valid); end
    // Offer an illegal command while the response is pending. It must be ignored.
    cmd_valid = 1'b1; cmd_op = 4'hB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 4'hF || rsp_err !== 1'b0 || cmd_ready !== 1'b0 || A !== 4'h5) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b r=%h e=%b rdy=%b A=%h exp v=1 r=f e=0 rdy=0 A=5", i, rsp_valid, rsp_result, rsp_err, cmd_ready, A);
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== c0 + 8'd1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b cnt=%0d exp 0/1/%0d", rsp_valid, cmd_ready, op_count, c0 + 8'd1); end
    run_cmd(4'h4, 4'h3, 4'h0, 1'b0, 1'b0, lat, r, f, e);
    checks++; if (r !== 4'hC || e !== 1'b0 || lat !== 2) begin errors++; $display("FAIL bp_next got=%h/%b lat=%0d exp=c/0/2", r, e, lat); end
  endtask

  task automatic test_reset_exec();
    int lat; logic [3:0] r; logic f, e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h2; cmd_a = 4'h6; cmd_b = 4'h6; cmd_chain = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 8'd0) begin errors++; $display("FAIL rst_exec got v=%b rdy=%b cnt=%0d exp 0/1/0", rsp_valid, cmd_ready, op_count); end
    checks++; if ({A, B, ALUFlagIN, ALUControl, rsp_result, rsp_flag, rsp_err} !== 19'd0) begin errors++; $display("FAIL rst_exec_outputs got=%h/%h/%h/%h exp=0", A, B, ALUControl, rsp_result); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_no_rsp got=%b exp=0", rsp_valid); end
    // last_result was cleared: 0 ^ 5 = 5
    run_cmd(4'h3, 4'h9, 4'h5, 1'b0, 1'b1, lat, r, f, e);
    checks++; if (r !== 4'h5) begin errors++; $display("FAIL rst_last_result got=%h exp=5", r); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [3:0] r; logic f, e; int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      run_cmd(4'h5, 4'h0, i[3:0], 1'b0, 1'b0, lat, r, f, e);
      if (r !== i[3:0] || lat !== 2) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_results got=%0d bad exp=0", bad); end
    checks++; if (op_count !== 8'd255) begin errors++; $display("FAIL b2b_count255 got=%0d exp=255", op_count); end
    run_cmd(4'h5, 4'h0, 4'h1, 1'b0, 1'b0, lat, r, f, e);
    checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL b2b_wrap got=%0d exp=0", op_count); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 4'h0; cmd_b = 4'h0;
    cmd_flagin = 1'b0; cmd_chain = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_add_carry();
    test_chain();
    test_illegal();
    test_flag_ops();
    test_backpressure();
    test_reset_exec();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
